// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
// Requester 0 is the core, requester 1 is the debug port.
package regfile_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;

  localparam logic REQ_CORE  = 1'b0;
  localparam logic REQ_DEBUG = 1'b1;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD_WAIT,
    RSP
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selector with a last-granted pointer (core wins first after reset).
// With RFARB_DEBUG_PRIO_EN defined the debug requester always wins and the pointer is unused.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic               gnt_idx
);

`ifdef RFARB_DEBUG_PRIO_EN
  assign gnt_idx = req[REQ_DEBUG] ? REQ_DEBUG : REQ_CORE;
`else
  logic last_q;

  always_comb begin
    gnt_idx = req[REQ_DEBUG] ? REQ_DEBUG : REQ_CORE;
    if (&req) gnt_idx = ~last_q;
  end

  // Starting as "debug last" makes the core win the first contended grant.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      last_q <= REQ_DEBUG;
    end else if (en) begin
      last_q <= gnt_idx;
    end
  end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Serialises core and debug accesses onto a 4x8 register file, one transaction at a time.
// Build option RFARB_DEBUG_PRIO_EN (in rr_arb2) switches round-robin to fixed debug priority.
//
// state   | meaning
// INIT    | pulse rf_sync_rst for one cycle after reset
// IDLE    | grant a requester and drive the register file
// RD_WAIT | register file output valid; capture read data
// RSP     | present response to the granted requester until accepted
module regfile_arbiter
  import regfile_arb_pkg::*;
(
  input  logic                           clk,
  input  logic                           async_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_a,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_b,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_W-1:0]              rsp_data_a,
  output logic [DATA_W-1:0]              rsp_data_b,
  output logic                           rf_sync_rst,
  output logic                           rf_read_en_a,
  output logic                           rf_read_en_b,
  output logic                           rf_write_en,
  output logic [ADDR_W-1:0]              rf_addr_read_a,
  output logic [ADDR_W-1:0]              rf_addr_read_b,
  output logic [ADDR_W-1:0]              rf_addr_write,
  output logic [DATA_W-1:0]              rf_data_in,
  input  logic [DATA_W-1:0]              rf_data_out_a,
  input  logic [DATA_W-1:0]              rf_data_out_b
);

  state_e            state_q, state_d;
  logic              gnt_q;
  op_e               op_q;
  logic [DATA_W-1:0] rsp_data_a_q, rsp_data_b_q;
  logic              grant_en;
  logic              gnt_idx;

  assign grant_en = (state_q == IDLE) && (|req_valid);

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .req         (req_valid),
    .en          (grant_en),
    .gnt_idx     (gnt_idx)
  );

  always_comb begin
    state_d        = state_q;
    req_ready      = '0;
    rsp_valid      = '0;
    rf_sync_rst    = 1'b0;
    rf_read_en_a   = 1'b0;
    rf_read_en_b   = 1'b0;
    rf_write_en    = 1'b0;
    rf_addr_read_a = '0;
    rf_addr_read_b = '0;
    rf_addr_write  = '0;
    rf_data_in     = '0;
    case (state_q)
      INIT: begin
        rf_sync_rst = 1'b1;
        state_d     = IDLE;
      end
      IDLE: begin
        if (grant_en) begin
          req_ready[gnt_idx] = 1'b1;
          if (req_we[gnt_idx]) begin
            rf_write_en   = 1'b1;
            rf_addr_write = req_addr_a[gnt_idx];
            rf_data_in    = req_wdata[gnt_idx];
            state_d       = RSP;
          end else begin
            rf_read_en_a   = 1'b1;
            rf_read_en_b   = 1'b1;
            rf_addr_read_a = req_addr_a[gnt_idx];
            rf_addr_read_b = req_addr_b[gnt_idx];
            state_d        = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_d = RSP;
      RSP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q      <= INIT;
      gnt_q        <= REQ_CORE;
      op_q         <= OP_READ;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        gnt_q <= gnt_idx;
        op_q  <= req_we[gnt_idx] ? OP_WRITE : OP_READ;
        // Writes return zero data so a stale read result never leaks out.
        if (req_we[gnt_idx]) begin
          rsp_data_a_q <= '0;
          rsp_data_b_q <= '0;
        end
      end
      if ((state_q == RD_WAIT) && (op_q == OP_READ)) begin
        rsp_data_a_q <= rf_data_out_a;
        rsp_data_b_q <= rf_data_out_b;
      end
    end
  end

  assign rsp_data_a = rsp_data_a_q;
  assign rsp_data_b = rsp_data_b_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: transaction-level model checked every cycle
// plus literal expectations on grant order, latency and returned data.
module tb_regfile_arbiter;

  logic             clk = 1'b0;
  logic             async_rst_n;
  logic [1:0]       req_valid, req_ready, req_we;
  logic [1:0][1:0]  req_addr_a, req_addr_b;
  logic [1:0][7:0]  req_wdata;
  logic [1:0]       rsp_valid, rsp_ready;
  logic [7:0]       rsp_data_a, rsp_data_b;
  logic             rf_sync_rst, rf_read_en_a, rf_read_en_b, rf_write_en;
  logic [1:0]       rf_addr_read_a, rf_addr_read_b, rf_addr_write;
  logic [7:0]       rf_data_in;
  logic [7:0]       rf_data_out_a = 8'h00, rf_data_out_b = 8'h00;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .rf_sync_rst(rf_sync_rst), .rf_read_en_a(rf_read_en_a), .rf_read_en_b(rf_read_en_b),
    .rf_write_en(rf_write_en), .rf_addr_read_a(rf_addr_read_a), .rf_addr_read_b(rf_addr_read_b),
    .rf_addr_write(rf_addr_write), .rf_data_in(rf_data_in),
    .rf_data_out_a(rf_data_out_a), .rf_data_out_b(rf_data_out_b)
  );

  // Register file the arbiter drives
  logic [7:0] rf_mem [4];
  always @(posedge clk) begin
    if (rf_sync_rst) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
    end else if (rf_write_en) begin
      rf_mem[rf_addr_write] <= rf_data_in;
    end
    if (rf_read_en_a) rf_data_out_a <= rf_mem[rf_addr_read_a];
    if (rf_read_en_b) rf_data_out_b <= rf_mem[rf_addr_read_b];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic vcheck(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one transaction in flight, response due a fixed
  // number of cycles after the grant, contents tracked as a plain array.
  int         m_cyc, m_owner, m_rsp_at, m_last, w;
  bit         m_busy, grant;
  logic [7:0] m_da, m_db;
  logic [7:0] m_mem [4];
  logic [1:0] e_ready, e_rsp;

  // Observations for the literal checks
  int         cyc_abs = 0, last_gnt_cyc = 0, rsp_rise_cyc = 0;
  int         sync_cnt = 0, rsp_cnt = 0, rsp1_cnt = 0, ready_cnt = 0;
  int         hs_owner = -1;
  logic [7:0] hs_a, hs_b;
  logic [1:0] prev_rsp = 2'b00;
  int         gnt_log[$];

  always @(negedge clk) begin
    cyc_abs++;
    if (!async_rst_n) begin
      m_cyc = 0; m_busy = 0; m_last = 1;
      vcheck("rst_req_ready", req_ready, 0);
      vcheck("rst_rsp_valid", rsp_valid, 0);
      vcheck("rst_rf_en", {rf_write_en, rf_read_en_a, rf_read_en_b}, 0);
      vcheck("rst_rsp_data", {rsp_data_a, rsp_data_b}, 0);
    end else if (m_cyc == 0) begin
      vcheck("init_sync_rst", rf_sync_rst, 1);
      vcheck("init_req_ready", req_ready, 0);
      vcheck("init_rf_en", {rf_write_en, rf_read_en_a, rf_read_en_b}, 0);
      vcheck("init_rsp_valid", rsp_valid, 0);
      for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
      m_cyc = 1;
    end else begin
      e_rsp = (m_busy && m_cyc >= m_rsp_at) ? (2'b01 << m_owner) : 2'b00;
      grant = !m_busy && (req_valid != 2'b00);
`ifdef RFARB_DEBUG_PRIO_EN
      w = req_valid[1] ? 1 : 0;
`else
      if (req_valid == 2'b11) w = 1 - m_last;
      else w = req_valid[1] ? 1 : 0;
`endif
      e_ready = grant ? (2'b01 << w) : 2'b00;
      vcheck("req_ready", req_ready, e_ready);
      vcheck("rsp_valid", rsp_valid, e_rsp);
      vcheck("rf_sync_rst", rf_sync_rst, 0);
      vcheck("rf_write_en", rf_write_en, grant && req_we[w]);
      vcheck("rf_read_en", {rf_read_en_a, rf_read_en_b}, (grant && !req_we[w]) ? 2'b11 : 2'b00);
      if (grant && req_we[w]) begin
        vcheck("rf_addr_write", rf_addr_write, req_addr_a[w]);
        vcheck("rf_data_in", rf_data_in, req_wdata[w]);
      end
      if (grant && !req_we[w]) begin
        vcheck("rf_addr_read_a", rf_addr_read_a, req_addr_a[w]);
        vcheck("rf_addr_read_b", rf_addr_read_b, req_addr_b[w]);
      end
      if (e_rsp != 2'b00) begin
        vcheck("rsp_data_a", rsp_data_a, m_da);
        vcheck("rsp_data_b", rsp_data_b, m_db);
        if (rsp_ready[m_owner]) m_busy = 0;
      end
      if (grant) begin
        m_busy = 1; m_owner = w; m_last = w;
        if (req_we[w]) begin
          m_rsp_at = m_cyc + 1;
          m_mem[req_addr_a[w]] = req_wdata[w];
          m_da = 8'h00; m_db = 8'h00;
        end else begin
          m_rsp_at = m_cyc + 2;
          m_da = m_mem[req_addr_a[w]];
          m_db = m_mem[req_addr_b[w]];
        end
      end
      m_cyc++;
    end
    if (async_rst_n) begin
      if (rf_sync_rst) sync_cnt++;
      if (rsp_valid != 2'b00) rsp_cnt++;
      if (rsp_valid[1]) rsp1_cnt++;
      if (req_ready != 2'b00) begin
        ready_cnt++;
        last_gnt_cyc = cyc_abs;
        gnt_log.push_back(req_ready[1] ? 1 : 0);
      end
      if (rsp_valid != 2'b00 && prev_rsp == 2'b00) rsp_rise_cyc = cyc_abs;
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        hs_owner = rsp_valid[1] ? 1 : 0;
        hs_a = rsp_data_a;
        hs_b = rsp_data_b;
      end
    end
    prev_rsp = async_rst_n ? rsp_valid : 2'b00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[idx] && n < 50);
    vcheck("accept_seen", req_ready[idx], 1);
  endtask

  task automatic wait_rsp(input int idx);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[idx] && n < 50);
    vcheck("rsp_seen", rsp_valid[idx], 1);
  endtask

  task automatic do_txn(input int idx, input logic we, input logic [1:0] a, input logic [1:0] b,
                        input logic [7:0] wd);
    req_we[idx] = we; req_addr_a[idx] = a; req_addr_b[idx] = b; req_wdata[idx] = wd;
    req_valid[idx] = 1'b1;
    rsp_ready[idx] = 1'b1;
    wait_ready(idx);
    tick();
    req_valid[idx] = 1'b0;
    wait_rsp(idx);
    tick();
  endtask

  int exp_g[4];
  int snap;

  initial begin
    async_rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr_a = '0; req_addr_b = '0; req_wdata = '0;
    rsp_ready = 2'b11;
    repeat (3) tick();
    async_rst_n = 1'b1;
    repeat (4) tick();
    vcheck("sync_rst_cycles", sync_cnt, 1);
    vcheck("ready_before_use", ready_cnt, 0);

    // Core write r2 = 0x5A, then read a=2 b=0
    do_txn(0, 1'b1, 2'd2, 2'd0, 8'h5A);
    vcheck("wr_latency", rsp_rise_cyc - last_gnt_cyc, 1);
    vcheck("wr_rsp_data", {hs_a, hs_b}, 16'h0000);
    do_txn(0, 1'b0, 2'd2, 2'd0, 8'h00);
    vcheck("rd_latency", rsp_rise_cyc - last_gnt_cyc, 2);
    vcheck("rd_data_a", hs_a, 8'h5A);
    vcheck("rd_data_b", hs_b, 8'h00);

    // Both requesters continuously valid, starting from reset
    async_rst_n = 1'b0;
    tick(); tick();
    async_rst_n = 1'b1;
    tick(); tick();
    gnt_log.delete();
    req_we = 2'b00;
    req_addr_a[0] = 2'd0; req_addr_b[0] = 2'd1;
    req_addr_a[1] = 2'd2; req_addr_b[1] = 2'd3;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int n = 0; n < 60 && gnt_log.size() < 4; n++) tick();
    req_valid = 2'b00;
    repeat (5) tick();
`ifdef RFARB_DEBUG_PRIO_EN
    exp_g = '{1, 1, 1, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    vcheck("grant_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) vcheck("grant_order", (i < gnt_log.size()) ? gnt_log[i] : -1, exp_g[i]);

    // Held response: debug read with rsp_ready low, core waiting behind it
    do_txn(1, 1'b1, 2'd1, 2'd0, 8'h3C);
    req_we[1] = 1'b0; req_addr_a[1] = 2'd1; req_addr_b[1] = 2'd2;
    rsp_ready = 2'b01;
    req_valid[1] = 1'b1;
    wait_ready(1);
    tick();
    req_valid[1] = 1'b0;
    req_we[0] = 1'b0; req_addr_a[0] = 2'd1; req_addr_b[0] = 2'd1;
    req_valid[0] = 1'b1;
    snap = ready_cnt;
    repeat (7) tick();
    vcheck("ready_during_hold", ready_cnt - snap, 0);
    vcheck("rsp_held", rsp_valid, 2'b10);
    rsp_ready[1] = 1'b1;
    tick();
    vcheck("held_rsp_data", {hs_a, hs_b}, 16'h3C00);
    wait_ready(0);
    tick();
    req_valid[0] = 1'b0;
    wait_rsp(0);
    tick();
    vcheck("core_after_hold", {hs_a, hs_b}, 16'h3C3C);

    // Reset pulsed while the read sits in RD_WAIT
    req_we[0] = 1'b0; req_addr_a[0] = 2'd1; req_addr_b[0] = 2'd1;
    req_valid[0] = 1'b1;
    wait_ready(0);
    tick();
    req_valid[0] = 1'b0;
    async_rst_n = 1'b0;
    sync_cnt = 0;
    snap = rsp_cnt;
    tick();
    async_rst_n = 1'b1;
    repeat (8) tick();
    vcheck("rsp_after_reset", rsp_cnt - snap, 0);
    vcheck("sync_rst_after_pulse", sync_cnt, 1);

    // Debug write r3 = 0xFF, core reads it back
    do_txn(1, 1'b1, 2'd3, 2'd0, 8'hFF);
    snap = rsp1_cnt;
    do_txn(0, 1'b0, 2'd3, 2'd3, 8'h00);
    vcheck("raw_data", {hs_a, hs_b}, 16'hFFFF);
    vcheck("raw_owner", hs_owner, 0);
    vcheck("raw_no_debug_rsp", rsp1_cnt - snap, 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 2, requester count; index 0 = core, index 1 = debug; fixed at 2.
REQ-002 Parameter: DATA_W, 8, register width; matches 4-entry x 8-bit register file.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Port names are clk and async_rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 async_rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  2  per-requester request valid.
REQ-007 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-008 req_we  in  2  1 = write, 0 = dual read.
REQ-009 req_addr_a / req_addr_b  in  2x2 each  read addresses; addr_a is also the write address.
REQ-010 req_wdata  in  2x8  write data.
REQ-011 rsp_valid  out  2  per-requester response valid.
REQ-012 rsp_ready  in  2  per-requester response accept.
REQ-013 rsp_data_a / rsp_data_b  out  8 each  shared read data, qualified by rsp_valid.
REQ-014 rf_sync_rst, rf_read_en_a, rf_read_en_b, rf_write_en  out  1 each  register-file controls.
REQ-015 rf_addr_read_a, rf_addr_read_b, rf_addr_write  out  2 each; rf_data_in  out  8.
REQ-016 rf_data_out_a / rf_data_out_b  in  8 each  register-file outputs, registered one cycle after read enable.

Function
REQ-017 FSM states SHALL be INIT, IDLE, RD_WAIT and RSP; at most one transaction is outstanding.
REQ-018 INIT: rf_sync_rst=1 for exactly one cycle, req_ready=0; next state IDLE.
REQ-019 IDLE, any req_valid: grant one requester g; req_ready[g]=1 combinationally in the same cycle; latch g, op and addresses.
REQ-020 Granted write: rf_write_en=1, rf_addr_write=addr_a[g], rf_data_in=wdata[g] in the grant cycle; next RSP; rsp_data = 0.
REQ-021 Granted read: rf_read_en_a=rf_read_en_b=1 with addr_a[g]/addr_b[g] in the grant cycle; next RD_WAIT.
REQ-022 RD_WAIT: capture rf_data_out_a/b into response registers; next RSP.
REQ-023 Latency (accept at cycle T): read rsp_valid at T+2; write rsp_valid at T+1.
REQ-024 RSP: rsp_valid[g]=1 and data held stable until rsp_ready[g]=1; that cycle returns to IDLE with no grant.
REQ-025 Outside grant cycles, all rf enables SHALL be 0 and req_ready SHALL be 0.
REQ-026 Round-robin: with both valid, the requester not most recently granted wins; pointer updates only on grant; after reset, core wins.
REQ-027 Requesters SHALL hold valid and fields stable until accepted; the arbiter does not sample unaccepted requests.
REQ-028 Read after write: serialization guarantees a read accepted after a write's response sees the written value.
REQ-029 rsp_ready on a non-granted index, or outside RSP, SHALL be ignored.

Reset
REQ-030 async_rst_n low: state=INIT, RR pointer=core, rsp_valid=0, req_ready=0, rsp_data=0, all rf enables 0.
REQ-031 Reset mid-transaction drops it silently; the requester reissues.
REQ-032 After release, the first grant is no earlier than the second rising edge.

Configuration
REQ-033 Macro RFARB_DEBUG_PRIO_EN defined: requester 1 wins whenever valid in IDLE (fixed priority); RR pointer unused.
REQ-034 Macro undefined: round-robin per REQ-026.

Structure
REQ-035 Package regfile_arb_pkg SHALL hold the state enum, op enum (OP_READ/OP_WRITE), NUM_REQ, DATA_W and the requester index constants.
REQ-036 Sub-module rr_arb2 SHALL be the 2-way round-robin grant plus pointer; the FSM and datapath stay in regfile_arbiter.

Verification
REQ-037 Reset release -> rf_sync_rst high exactly one cycle, then IDLE; no req_ready before that.
REQ-038 Core write r2=0x5A, then core read a=2, b=0 -> rsp_data_a=0x5A, b=0x00; rsp_valid at T+2.
REQ-039 Both valid continuously -> grants alternate core, debug, core, debug (macro off); debug, debug, ... (macro on).
REQ-040 rsp_ready held low 5 cycles -> rsp_valid and data stable; no new req_ready until the handshake completes.
REQ-041 async_rst_n pulsed during RD_WAIT -> rsp_valid never asserts for that request; INIT follows.
REQ-042 Debug write r3=0xFF, then core read r3 -> 0xFF; only rsp_valid[0] asserts for the read.
